// File: rtl/txn_mem.sv
// txn_mem: latency-modelling memory slave with a preloadable read bank and a separate write bank.
// Build option TXN_MEM_RDBACK_EN: reads that decode inside the write bank return its contents.
module txn_mem #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 128,
  parameter int                LATENCY   = 4,
  parameter logic [ADDR_W-1:0] RD_BASE   = 32'h4000_0000,
  parameter logic [ADDR_W-1:0] WR_BASE   = 32'h4000_2000,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              txn_req,
  input  logic              txn_wr,
  input  logic [ADDR_W-1:0] txn_addr,
  input  logic [DATA_W-1:0] txn_wdata,
  output logic [DATA_W-1:0] txn_rdata,
  output logic              txn_rdy,
  output logic              txn_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is accepted on a rising edge where txn_req=1 and txn_rdy=1;
  // txn_rdy stays low until the completion edge, and txn_req is ignored while busy.

  localparam int BYTE_W = DATA_W / 8;
  localparam int OFF_SH = $clog2(BYTE_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTE_W - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              accept, done;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] rd_mem [DEPTH];
  logic [DATA_W-1:0] wr_mem [DEPTH];

  // Address decode against each bank, evaluated on the latched address.
  logic [ADDR_W-1:0] rd_word, wr_word;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              misalign, rd_bank_flt, wr_flt;

  assign misalign    = (addr_q & OFF_MASK) != '0;
  assign rd_word     = (addr_q - RD_BASE) >> OFF_SH;
  assign wr_word     = (addr_q - WR_BASE) >> OFF_SH;
  assign rd_idx      = rd_word[IDX_W-1:0];
  assign wr_idx      = wr_word[IDX_W-1:0];
  assign rd_bank_flt = (addr_q < RD_BASE) || (rd_word >= DEPTH_A) || misalign;
  assign wr_flt      = (addr_q < WR_BASE) || (wr_word >= DEPTH_A) || misalign;

  logic              rd_flt;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_flt = rd_bank_flt;
    rd_val = rd_mem[rd_idx];
`ifdef TXN_MEM_RDBACK_EN
    // Write-bank hit wins over the read bank.
    if (!wr_flt) begin
      rd_flt = 1'b0;
      rd_val = wr_mem[wr_idx];
    end
`endif
  end

  // FSM state register and latency counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (txn_req) begin
          accept  = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = txn_wr ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      txn_rdata <= '0;
      txn_err   <= 1'b0;
    end else begin
      txn_err <= done && ((state_q == RD_WAIT) ? rd_flt : wr_flt);
      if (accept) begin
        addr_q  <= txn_addr;
        wdata_q <= txn_wdata;
      end
      if (done && state_q == RD_WAIT) begin
        txn_rdata <= rd_flt ? '0 : rd_val;
      end
    end
  end

  // Bank contents are not reset; a reset drops the FSM to IDLE so no commit can follow.
  always_ff @(posedge clk) begin
    if (done && state_q == WR_WAIT && !wr_flt) begin
      wr_mem[wr_idx] <= wdata_q;
    end
  end

  assign txn_rdy   = (state_q == IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_txn_mem.sv
// Directed bench for txn_mem: LATENCY=4 instance plus a LATENCY=0 instance sharing clock and reset.
module tb_txn_mem;
  localparam int W   = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst_n;

  logic         txn_req, txn_wr;
  logic [W-1:0] txn_addr, txn_wdata, txn_rdata;
  logic         txn_rdy, txn_err;
  logic [1:0]   dbg_state;

  logic         req_z, wr_z;
  logic [W-1:0] addr_z, wdata_z, rdata_z;
  logic         rdy_z, err_z;
  logic [1:0]   dbg_z;

  txn_mem dut (
    .clk(clk), .arst_n(arst_n), .txn_req(txn_req), .txn_wr(txn_wr),
    .txn_addr(txn_addr), .txn_wdata(txn_wdata), .txn_rdata(txn_rdata),
    .txn_rdy(txn_rdy), .txn_err(txn_err), .dbg_state(dbg_state)
  );

  txn_mem #(.LATENCY(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .txn_req(req_z), .txn_wr(wr_z),
    .txn_addr(addr_z), .txn_wdata(wdata_z), .txn_rdata(rdata_z),
    .txn_rdy(rdy_z), .txn_err(err_z), .dbg_state(dbg_z)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=4 instance; busy counts low-rdy cycles seen on falling edges.
  task automatic do_txn(input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                        output int busy, output logic [W-1:0] rd,
                        output logic err_at, output logic err_after);
    @(negedge clk);
    txn_req = 1'b1; txn_wr = wr; txn_addr = addr; txn_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    txn_req = 1'b0;
    busy = 0;
    while (!txn_rdy && busy < 300) begin
      busy++;
      @(negedge clk);
    end
    rd     = txn_rdata;
    err_at = txn_err;
    @(negedge clk);
    err_after = txn_err;
  endtask

  int           busy, extra_busy, extra_err;
  logic [W-1:0] rd;
  logic         e0, e1;

  initial begin
    arst_n = 1'b0;
    txn_req = 1'b0; txn_wr = 1'b0; txn_addr = '0; txn_wdata = '0;
    req_z = 1'b0; wr_z = 1'b0; addr_z = '0; wdata_z = '0;
    #1;
    dut.rd_mem[0]   = 32'h0000_0011;
    dut.rd_mem[5]   = 32'hA5A5_0005;
    dut.rd_mem[127] = 32'h0000_7F7F;
    dut0.rd_mem[0]  = 32'h0000_0011;
    repeat (3) @(negedge clk);
    check("rst_rdy", W'(txn_rdy), 1);
    check("rst_rdata", txn_rdata, 0);
    check("rst_err", W'(txn_err), 0);
    check("rst_state", W'(dbg_state), 0);
    arst_n = 1'b1;

    // Plain read of word 0
    exp_q.push_back(32'h0000_0011);
    do_txn(1'b0, 32'h4000_0000, '0, busy, rd, e0, e1);
    check("rd0_busy", W'(busy), LAT + 1);
    check("rd0_data", rd, exp_q.pop_front());
    check("rd0_err", W'(e0), 0);

    // Write into write bank index 2; read data must hold
    do_txn(1'b1, 32'h4000_2008, 32'hDEAD_BEEF, busy, rd, e0, e1);
    check("wr2_busy", W'(busy), LAT + 1);
    check("wr2_mem", dut.wr_mem[2], 32'hDEAD_BEEF);
    check("wr2_rdata", rd, 32'h0000_0011);
    check("wr2_err", W'(e0), 0);

    // Last valid index of the read bank
    exp_q.push_back(32'h0000_7F7F);
    do_txn(1'b0, 32'h4000_01FC, '0, busy, rd, e0, e1);
    check("rd127_data", rd, exp_q.pop_front());
    check("rd127_err", W'(e0), 0);

    // One past the end faults, returns 0, err lasts one cycle
    do_txn(1'b0, 32'h4000_0200, '0, busy, rd, e0, e1);
    check("rd128_data", rd, 0);
    check("rd128_err", W'(e0), 1);
    check("rd128_err_next", W'(e1), 0);

    // Good write then misaligned write to the same word
    do_txn(1'b1, 32'h4000_2000, 32'h0000_1234, busy, rd, e0, e1);
    check("wr0_err", W'(e0), 0);
    do_txn(1'b1, 32'h4000_2001, 32'h0000_0BAD, busy, rd, e0, e1);
    check("wrmis_err", W'(e0), 1);
    check("wrmis_err_next", W'(e1), 0);
    check("wrmis_mem", dut.wr_mem[0], 32'h0000_1234);

    // Below base and misaligned reads
    do_txn(1'b0, 32'h3FFF_FFFC, '0, busy, rd, e0, e1);
    check("rdlow_err", W'(e0), 1);
    check("rdlow_data", rd, 0);
    do_txn(1'b0, 32'h4000_0002, '0, busy, rd, e0, e1);
    check("rdmis_err", W'(e0), 1);

    // Write-bank readback
    do_txn(1'b1, 32'h4000_2004, 32'h0000_0005, busy, rd, e0, e1);
    check("wr1_err", W'(e0), 0);
    do_txn(1'b0, 32'h4000_2004, '0, busy, rd, e0, e1);
`ifdef TXN_MEM_RDBACK_EN
    check("rdback_data", rd, 32'h0000_0005);
    check("rdback_err", W'(e0), 0);
`else
    check("rdback_data", rd, 0);
    check("rdback_err", W'(e0), 1);
`endif

    // txn_req toggled while waiting must not start anything
    exp_q.push_back(32'hA5A5_0005);
    @(negedge clk);
    txn_req = 1'b1; txn_wr = 1'b0; txn_addr = 32'h4000_0014;
    @(posedge clk);
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      txn_addr = 32'h4000_0000;
      txn_req  = (i % 2 == 1) ? 1'b0 : 1'b1;
      if (!txn_rdy) busy++;
    end
    txn_req = 1'b0;
    @(negedge clk);
    while (!txn_rdy && busy < 300) begin
      busy++;
      @(negedge clk);
    end
    check("tgl_busy", W'(busy), LAT + 1);
    check("tgl_data", txn_rdata, exp_q.pop_front());
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!txn_rdy) extra_busy++;
    end
    check("tgl_extra", W'(extra_busy), 0);

    // Reset two cycles into a write to index 2
    @(negedge clk);
    txn_req = 1'b1; txn_wr = 1'b1; txn_addr = 32'h4000_2008; txn_wdata = 32'h5555_5555;
    @(posedge clk);
    @(negedge clk);
    txn_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("prerst_busy", W'(txn_rdy), 0);
    arst_n = 1'b0;
    #1;
    check("midrst_rdy", W'(txn_rdy), 1);
    check("midrst_rdata", txn_rdata, 0);
    check("midrst_err", W'(txn_err), 0);
    @(negedge clk);
    arst_n = 1'b1;
    extra_busy = 0;
    extra_err  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!txn_rdy) extra_busy++;
      if (txn_err) extra_err++;
    end
    check("midrst_busy", W'(extra_busy), 0);
    check("midrst_errcnt", W'(extra_err), 0);
    check("midrst_mem", dut.wr_mem[2], 32'hDEAD_BEEF);

    // LATENCY=0 instance: busy for exactly one cycle
    exp_q.push_back(32'h0000_0011);
    @(negedge clk);
    req_z = 1'b1; wr_z = 1'b0; addr_z = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    req_z = 1'b0;
    busy = 0;
    while (!rdy_z && busy < 300) begin
      busy++;
      @(negedge clk);
    end
    check("z_busy", W'(busy), 1);
    check("z_data", rdata_z, exp_q.pop_front());
    check("z_err", W'(err_z), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
